// File: rtl/eight_to_three_priority_encoder.sv
// eight_to_three_priority_encoder
//
// Captures up to eight sticky request lines and presents them one at a time as
// a 3-bit code, highest index first, with a valid/ack handshake.
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst_n    in   1  synchronous active-low reset
//   enable   in   1  sample D on this edge when high
//   D        in   8  request lines, D[7] highest priority
//   ack      in   1  consumer accepts the presented code on this edge
//   Y        out  3  code of the presented request
//   valid    out  1  Y holds a code not yet acknowledged
//   pending  out  8  captured requests not yet presented
//   overflow out  1  sticky: a request arrived while its bit was still pending

module eight_to_three_priority_encoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] D,
    input  logic       ack,
    output logic [2:0] Y,
    output logic       valid,
    output logic [7:0] pending,
    output logic       overflow
);

    typedef enum logic [0:0] {StIdle, StPresent} state_e;

    state_e     state_q, state_d;
    logic [2:0] y_q, y_d;
    logic       valid_q, valid_d;
    logic [7:0] pending_q, pending_d;
    logic       overflow_q, overflow_d;

    logic [2:0] sel;
    logic [7:0] capture;
    logic [7:0] clear;
    logic       load;

    // Highest set index of the registered pending vector; later iterations
    // overwrite earlier ones, so the top set bit wins.
    always_comb begin
        sel = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (pending_q[k]) begin
                sel = 3'(k);
            end
        end
    end

    assign load    = (state_q == StIdle) && (pending_q != 8'h00);
    assign clear   = load ? (8'h01 << sel) : 8'h00;
    assign capture = enable ? D : 8'h00;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        valid_d = valid_q;

        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                if (load) begin
                    y_d     = sel;
                    valid_d = 1'b1;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase

        // Capture is OR-ed after the clear so a new request for the bit being
        // loaded survives; only a bit that stays pending can overflow.
        pending_d  = (pending_q & ~clear) | capture;
        overflow_d = overflow_q | (|(capture & pending_q & ~clear));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            y_q        <= 3'b000;
            valid_q    <= 1'b0;
            pending_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            valid_q    <= valid_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign Y        = y_q;
    assign valid    = valid_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_eight_to_three_priority_encoder.sv
module tb_eight_to_three_priority_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] D = 8'h00;
    logic       ack = 1'b0;
    logic [2:0] Y;
    logic       valid;
    logic [7:0] pending;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a set of outstanding request indices, the code on
    // display (if any) and a lost-request flag.
    bit m_req [8];
    int m_code;
    bit m_showing;
    bit m_lost;

    eight_to_three_priority_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .D        (D),
        .ack      (ack),
        .Y        (Y),
        .valid    (valid),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_pending();
        logic [7:0] v = 8'h00;
        for (int k = 0; k < 8; k++) if (m_req[k]) v += 8'(1 << k);
        return v;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void model_edge();
        int top = -1;
        if (!rst_n) begin
            foreach (m_req[k]) m_req[k] = 1'b0;
            m_code    = 0;
            m_showing = 1'b0;
            m_lost    = 1'b0;
            return;
        end
        for (int k = 7; k >= 0; k--) if (m_req[k] && top < 0) top = k;
        if (m_showing) begin
            if (ack) m_showing = 1'b0;
        end else if (top >= 0) begin
            m_code     = top;
            m_showing  = 1'b1;
            m_req[top] = 1'b0;
        end
        if (enable) begin
            for (int k = 0; k < 8; k++) begin
                if (D[k]) begin
                    if (m_req[k]) m_lost = 1'b1;
                    m_req[k] = 1'b1;
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("Y", {5'b0, Y}, 8'(m_code));
        check("valid", {7'b0, valid}, {7'b0, m_showing});
        check("pending", pending, model_pending());
        check("overflow", {7'b0, overflow}, {7'b0, m_lost});
    endtask

    task automatic drive(input logic r, input logic e, input logic [7:0] d, input logic a);
        rst_n  = r;
        enable = e;
        D      = d;
        ack    = a;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b1, 8'hFF, 1'b1);
        tick();
        drive(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        // Reset with busy inputs.
        do_reset();
        check("rst_Y", {5'b0, Y}, 8'h00);
        check("rst_valid", {7'b0, valid}, 8'h00);
        check("rst_pending", pending, 8'h00);
        check("rst_overflow", {7'b0, overflow}, 8'h00);

        // Single request: pending after edge 1, code after edge 2.
        drive(1'b1, 1'b1, 8'h20, 1'b0);
        tick();
        check("single_pend", pending, 8'h20);
        check("single_valid0", {7'b0, valid}, 8'h00);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        check("single_Y", {5'b0, Y}, 8'h05);
        check("single_valid", {7'b0, valid}, 8'h01);
        check("single_pend2", pending, 8'h00);
        tick();
        check("single_hold", {7'b0, valid}, 8'h01);
        ack = 1'b1;
        tick();
        check("single_acked", {7'b0, valid}, 8'h00);

        // Two extremes, ack held: 7, gap, 0.
        do_reset();
        drive(1'b1, 1'b1, 8'h81, 1'b1);
        tick();
        enable = 1'b0;
        tick();
        check("ext_Y7", {5'b0, Y}, 8'h07);
        check("ext_v1", {7'b0, valid}, 8'h01);
        tick();
        check("ext_gap", {7'b0, valid}, 8'h00);
        tick();
        check("ext_Y0", {5'b0, Y}, 8'h00);
        check("ext_v2", {7'b0, valid}, 8'h01);
        tick();
        check("ext_end", {7'b0, valid}, 8'h00);
        check("ext_ovf", {7'b0, overflow}, 8'h00);

        // Overflow: bit 2 re-requested while held behind bit 7.
        do_reset();
        drive(1'b1, 1'b1, 8'h84, 1'b0);
        tick();
        D = 8'h04;
        tick();
        check("ovf_set", {7'b0, overflow}, 8'h01);
        tick();
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        repeat (6) tick();
        check("ovf_sticky", {7'b0, overflow}, 8'h01);
        do_reset();
        check("ovf_clear", {7'b0, overflow}, 8'h00);

        // Disabled inputs are ignored.
        drive(1'b1, 1'b0, 8'hFF, 1'b0);
        repeat (3) tick();
        check("dis_pend", pending, 8'h00);
        check("dis_valid", {7'b0, valid}, 8'h00);

        // Capture wins over clear on the loading edge, then reset mid-present.
        drive(1'b1, 1'b1, 8'h80, 1'b0);
        tick();
        D = 8'hF0;
        tick();
        check("cw_pend", pending, 8'hF0);
        check("cw_valid", {7'b0, valid}, 8'h01);
        check("cw_ovf", {7'b0, overflow}, 8'h00);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        check("mid_Y", {5'b0, Y}, 8'h00);
        check("mid_valid", {7'b0, valid}, 8'h00);
        check("mid_pend", pending, 8'h00);
        check("mid_ovf", {7'b0, overflow}, 8'h00);

        // Full sweep with ack held.
        drive(1'b1, 1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 256; i++) begin
            D = 8'(i);
            tick();
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 40) != 0), 1'($urandom), 8'($urandom & $urandom),
                  ($urandom_range(0, 2) != 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
